// File: rtl/dualport_ram_ctl_if.sv
// ----------------------------------------------------------------------------
// dualport_ram_ctl_if
//
// Bus bundle for the shared-memory path between the J1 core (port 1) and the
// peripheral bus (port 2). The clock and reset are not part of the bundle.
//
// Signals:
//   busy                    clear sequence in progress, requests ignored
//   addr_1 / addr_2         port word address
//   d_in_1 / d_in_2         write data
//   rd_1 / rd_2             read request (wins over wr on the same port)
//   wr_1 / wr_2             write request
//   d_out_1 / d_out_2       read data, held until the next read on that port
//   vld_1 / vld_2           one-cycle pulse, d_out updated this cycle
//   coll                    one-cycle pulse, same-address write/write collision
//   coll_cnt                saturating collision count
//
// Modports:
//   master  requester side (drives requests, observes results)
//   slave   RAM controller side
// ----------------------------------------------------------------------------
interface dualport_ram_ctl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              busy;
    logic [ADDR_W-1:0] addr_1;
    logic [ADDR_W-1:0] addr_2;
    logic [DATA_W-1:0] d_in_1;
    logic [DATA_W-1:0] d_in_2;
    logic              rd_1;
    logic              rd_2;
    logic              wr_1;
    logic              wr_2;
    logic [DATA_W-1:0] d_out_1;
    logic [DATA_W-1:0] d_out_2;
    logic              vld_1;
    logic              vld_2;
    logic              coll;
    logic [7:0]        coll_cnt;

    modport master (
        output addr_1, addr_2, d_in_1, d_in_2, rd_1, rd_2, wr_1, wr_2,
        input  busy, d_out_1, d_out_2, vld_1, vld_2, coll, coll_cnt
    );

    modport slave (
        input  addr_1, addr_2, d_in_1, d_in_2, rd_1, rd_2, wr_1, wr_2,
        output busy, d_out_1, d_out_2, vld_1, vld_2, coll, coll_cnt
    );
endinterface

// File: rtl/dualport_ram_ctl.sv
// ----------------------------------------------------------------------------
// dualport_ram_ctl
//
// True dual-port RAM shared by the J1 core (port 1) and the peripheral bus
// (port 2). Both ports run on one clock. After reset the whole array is
// optionally cleared to zero, one word per cycle, while busy is high.
// Same-address write/write collisions are resolved by a fixed port priority
// and counted; a read on one port of a word being written by the other port
// in the same cycle returns the new data.
//
// Ports:
//   clk     single clock, all state on the rising edge
//   rst_n   asynchronous active-low reset
//   bus     dualport_ram_ctl_if.slave (requests in, read data/status out)
//
// Parameters:
//   DATA_W          word width
//   ADDR_W          address width, depth = 2**ADDR_W
//   CLEAR_ON_RESET  1 = zero the array after reset, 0 = start in RUN at once
//   P1_PRIO         1 = port 1 wins collisions, 0 = port 2 wins
// ----------------------------------------------------------------------------
module dualport_ram_ctl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit P1_PRIO        = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    dualport_ram_ctl_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] dOut1_q;
    logic [DATA_W-1:0] dOut2_q;
    logic              vld1_q;
    logic              vld2_q;
    logic              coll_q;
    logic [7:0]        collCnt_q;

    logic              running;
    logic              clearWe;
    logic              wrReq1;
    logic              wrReq2;
    logic              collide;
    logic              we1;
    logic              we2;
    logic [DATA_W-1:0] rdData1_d;
    logic [DATA_W-1:0] rdData2_d;

    // Request decode. Gating with rst_n keeps the array untouched while reset
    // is held, even in the CLEAR_ON_RESET=0 build where reset lands in RUN.
    // A read on a port suppresses that port's write for the cycle. On a
    // same-address collision only the priority port's write survives, and the
    // cross-port forward below sees only surviving writes.
    always_comb begin
        running   = rst_n && (state_q == RUN);
        clearWe   = rst_n && (state_q == CLEAR);
        wrReq1    = running && bus.wr_1 && !bus.rd_1;
        wrReq2    = running && bus.wr_2 && !bus.rd_2;
        collide   = wrReq1 && wrReq2 && (bus.addr_1 == bus.addr_2);
        we1       = wrReq1 && !(collide && !P1_PRIO);
        we2       = wrReq2 && !(collide && P1_PRIO);
        rdData1_d = (we2 && (bus.addr_2 == bus.addr_1)) ? bus.d_in_2 : mem[bus.addr_1];
        rdData2_d = (we1 && (bus.addr_1 == bus.addr_2)) ? bus.d_in_1 : mem[bus.addr_2];
    end

    // Storage array. Kept free of reset so it maps onto RAM; the clear
    // sequencer and the two ports never write in the same cycle because they
    // are qualified by different FSM states.
    always_ff @(posedge clk) begin
        if (clearWe) begin
            mem[ptr_q] <= '0;
        end
        if (we1) begin
            mem[bus.addr_1] <= bus.d_in_1;
        end
        if (we2) begin
            mem[bus.addr_2] <= bus.d_in_2;
        end
    end

    // Control FSM with registered read data, strobes and collision counter.
    // The clear pointer wraps back to zero on its final increment, so it is
    // already at its reset value when RUN is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : RUN;
            ptr_q     <= '0;
            dOut1_q   <= '0;
            dOut2_q   <= '0;
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
            coll_q    <= 1'b0;
            collCnt_q <= '0;
        end else begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            coll_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == {ADDR_W{1'b1}}) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.rd_1) begin
                        dOut1_q <= rdData1_d;
                        vld1_q  <= 1'b1;
                    end
                    if (bus.rd_2) begin
                        dOut2_q <= rdData2_d;
                        vld2_q  <= 1'b1;
                    end
                    if (collide) begin
                        coll_q <= 1'b1;
                        if (collCnt_q != 8'hFF) begin
                            collCnt_q <= collCnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign bus.busy     = (state_q == CLEAR);
    assign bus.d_out_1  = dOut1_q;
    assign bus.d_out_2  = dOut2_q;
    assign bus.vld_1    = vld1_q;
    assign bus.vld_2    = vld2_q;
    assign bus.coll     = coll_q;
    assign bus.coll_cnt = collCnt_q;

endmodule

// File: tb/tb_dualport_ram_ctl.sv
// ----------------------------------------------------------------------------
// tb_dualport_ram_ctl
//
// Self-checking bench for dualport_ram_ctl with default parameters
// (DATA_W=16, ADDR_W=8, CLEAR_ON_RESET=1, P1_PRIO=1). A behavioural model
// holds the memory as a plain array and derives every expected output from
// the port rules; directed scenarios are followed by a randomized phase on a
// narrow address window so collisions and forwarding happen often.
// ----------------------------------------------------------------------------
module tb_dualport_ram_ctl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst_n;

    dualport_ram_ctl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dualport_ram_ctl #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (1'b1),
        .P1_PRIO        (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int testCount;
    int failCount;

    // Reference model state
    logic [DATA_W-1:0] modelMem [DEPTH];
    int                edgesSinceRelease;
    int                collTotal;
    logic [DATA_W-1:0] expD1;
    logic [DATA_W-1:0] expD2;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model reset: the array will be zeroed by the clear sequence that
    // follows release, so the model starts from all zeros.
    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        edgesSinceRelease = 0;
        collTotal         = 0;
        expD1             = '0;
        expD2             = '0;
    endtask

    task automatic checkResetValues(input string where);
        checkOutput({where, ".busy"},    32'(bus.busy),     32'd1);
        checkOutput({where, ".dOut1"},   32'(bus.d_out_1),  32'd0);
        checkOutput({where, ".dOut2"},   32'(bus.d_out_2),  32'd0);
        checkOutput({where, ".vld1"},    32'(bus.vld_1),    32'd0);
        checkOutput({where, ".vld2"},    32'(bus.vld_2),    32'd0);
        checkOutput({where, ".coll"},    32'(bus.coll),     32'd0);
        checkOutput({where, ".collCnt"}, 32'(bus.coll_cnt), 32'd0);
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    // Release happens 1 unit after a rising edge.
    task automatic doReset(input string where);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetValues(where);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock of stimulus. Called 1 unit after a rising edge. Expected
    // outputs are derived from the model before the edge, then compared 1 unit
    // after the edge.
    task automatic applyStimulus(
        input logic              rd1, input logic wr1,
        input logic [ADDR_W-1:0] a1,  input logic [DATA_W-1:0] d1,
        input logic              rd2, input logic wr2,
        input logic [ADDR_W-1:0] a2,  input logic [DATA_W-1:0] d2
    );
        logic busyNow;
        logic w1;
        logic w2;
        logic expV1;
        logic expV2;
        logic expColl;
        int   expCnt;

        bus.rd_1 = rd1; bus.wr_1 = wr1; bus.addr_1 = a1; bus.d_in_1 = d1;
        bus.rd_2 = rd2; bus.wr_2 = wr2; bus.addr_2 = a2; bus.d_in_2 = d2;

        busyNow = (edgesSinceRelease < DEPTH);
        expV1   = 1'b0;
        expV2   = 1'b0;
        expColl = 1'b0;
        if (!busyNow) begin
            w1 = wr1 && !rd1;
            w2 = wr2 && !rd2;
            if (w1 && w2 && (a1 == a2)) begin
                expColl = 1'b1;
                collTotal++;
                w2 = 1'b0;
            end
            if (rd1) begin
                expV1 = 1'b1;
                expD1 = (w2 && (a2 == a1)) ? d2 : modelMem[a1];
            end
            if (rd2) begin
                expV2 = 1'b1;
                expD2 = (w1 && (a1 == a2)) ? d1 : modelMem[a2];
            end
            if (w1) modelMem[a1] = d1;
            if (w2) modelMem[a2] = d2;
        end
        edgesSinceRelease++;
        expCnt = (collTotal > 255) ? 255 : collTotal;

        @(posedge clk);
        #1;
        checkOutput("busy",    32'(bus.busy),     32'(edgesSinceRelease < DEPTH));
        checkOutput("vld1",    32'(bus.vld_1),    32'(expV1));
        checkOutput("vld2",    32'(bus.vld_2),    32'(expV2));
        checkOutput("coll",    32'(bus.coll),     32'(expColl));
        checkOutput("collCnt", 32'(bus.coll_cnt), 32'(expCnt));
        checkOutput("dOut1",   32'(bus.d_out_1),  32'(expD1));
        checkOutput("dOut2",   32'(bus.d_out_2),  32'(expD2));
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic readBoth(input logic [ADDR_W-1:0] a);
        applyStimulus(1'b1, 1'b0, a, '0, 1'b1, 1'b0, a, '0);
    endtask

    // Random request pattern, confined to a small address window.
    task automatic randomCycle(input int maxAddr);
        applyStimulus(
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ADDR_W'($urandom_range(0, maxAddr)), DATA_W'($urandom),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ADDR_W'($urandom_range(0, maxAddr)), DATA_W'($urandom));
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        modelReset();
        rst_n      = 1'b0;
        bus.rd_1   = 1'b0; bus.wr_1 = 1'b0; bus.addr_1 = '0; bus.d_in_1 = '0;
        bus.rd_2   = 1'b0; bus.wr_2 = 1'b0; bus.addr_2 = '0; bus.d_in_2 = '0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("por");
        rst_n = 1'b1;

        // Clear sequence with requests thrown at it; a write to 0x10 at
        // cycle 5 must not land.
        for (int c = 0; c < DEPTH; c++) begin
            if (c == 5)
                applyStimulus(1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, '0, '0);
            else
                randomCycle(DEPTH - 1);
        end

        // Cleared contents, including the write attempted while busy
        readBoth(8'h00);
        readBoth(8'h7F);
        readBoth(8'hFF);
        readBoth(8'h10);

        // Write/write collision, port 1 wins
        applyStimulus(1'b0, 1'b1, 8'h20, 16'h1111, 1'b0, 1'b1, 8'h20, 16'h2222);
        readBoth(8'h20);

        // Different-address simultaneous writes both land, no collision
        applyStimulus(1'b0, 1'b1, 8'h21, 16'hCAFE, 1'b0, 1'b1, 8'h22, 16'hF00D);
        applyStimulus(1'b1, 1'b0, 8'h21, '0, 1'b1, 1'b0, 8'h22, '0);

        // Cross-port forwarding in both directions
        applyStimulus(1'b0, 1'b1, 8'h33, 16'hA5A5, 1'b1, 1'b0, 8'h33, '0);
        applyStimulus(1'b1, 1'b0, 8'h34, '0, 1'b0, 1'b1, 8'h34, 16'h5A5A);
        readBoth(8'h33);

        // Same-port rd+wr: read wins, stored word unchanged
        applyStimulus(1'b0, 1'b1, 8'h40, 16'h0001, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b1, 8'h40, 16'h5555, 1'b0, 1'b0, '0, '0);
        readBoth(8'h40);

        // Randomized traffic on a narrow window
        for (int c = 0; c < 2000; c++) randomCycle(7);

        // 300 collisions drive the counter into saturation
        for (int c = 0; c < 300; c++)
            applyStimulus(1'b0, 1'b1, 8'h50, DATA_W'(c), 1'b0, 1'b1, 8'h50, 16'hFFFF);
        readBoth(8'h50);

        // Mid-run reset drops the saturated counter immediately
        doReset("midRun");
        for (int c = 0; c < 100; c++) randomCycle(DEPTH - 1);

        // Mid-clear reset, then a full-length clear and zeroed contents
        doReset("midClear");
        for (int c = 0; c < DEPTH; c++) idle();
        readBoth(8'h20);
        readBoth(8'h50);
        for (int c = 0; c < 200; c++) randomCycle(15);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
